id_ex_stage_reg: RTL and testbench
==================================

// Module: id_ex_stage_reg
// PURPOSE
//  ID/EX pipeline register fed by the decode-stage general control unit and the register file.
//  Latches the EX/MEM/WB control bundles and the decode operands for the EX stage.
//  Detects load-use hazards and issues stall_o back to the PC and IF/ID stages.
//  Inserts bubbles for load-use hazards and branch/jump flushes.
// PARAMETERS
//  DATA_W     32  width of operand, immediate and PC fields
//  RF_ADDR_W  5   register-file address width
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_i        in   1          reset, asynchronous, active-high
//  flush_i      in   1          kill the instruction entering EX (taken branch/jump)
//  hold_i       in   1          global freeze: all stage registers keep their value
//  EX_ctrl_i    in   5          {ALUop[2:0], ALUsrc, RegDst} from decode
//  MEM_ctrl_i   in   2          {MEM_cs, MEM_we} from decode
//  WB_ctrl_i    in   1          Reg_we/WB select from decode
//  pc_i         in   DATA_W     PC+4 of the decode instruction
//  rs_data_i    in   DATA_W     register-file read port A
//  rt_data_i    in   DATA_W     register-file read port B
//  imm_i        in   DATA_W     sign-extended immediate
//  rs_addr_i    in   RF_ADDR_W  instr[25:21]
//  rt_addr_i    in   RF_ADDR_W  instr[20:16]
//  rd_addr_i    in   RF_ADDR_W  instr[15:11]
//  EX_ctrl_o    out  5          registered copy, to EX
//  MEM_ctrl_o   out  2          registered copy, to EX/MEM
//  WB_ctrl_o    out  1          registered copy, to EX/MEM
//  pc_o, rs_data_o, rt_data_o, imm_o         out  DATA_W     registered copies
//  rs_addr_o, rt_addr_o, rd_addr_o           out  RF_ADDR_W  registered copies
//  valid_o      out  1          1 = EX holds a real instruction, 0 = bubble
//  stall_o      out  1          combinational load-use stall to the PC and IF/ID stages
// BEHAVIOUR
//  Reset (async, rst_i=1): every registered output = 0, valid_o = 0.
//  Latency: one clock from inputs to registered outputs.
//  load_in_ex = valid_o & MEM_ctrl_o[1] & ~MEM_ctrl_o[0].
//  stall_o = load_in_ex & (rt_addr_o != 0) & ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i)).
//   - Compares both sources regardless of opcode; the conservative extra stall is accepted.
//   - stall_o is forced to 0 while hold_i = 1 or flush_i = 1.
//  Update priority at each rising edge, highest first:
//   1. hold_i = 1: all registers hold; stall_o = 0.
//   2. flush_i = 1: load a bubble.
//   3. stall_o = 1: load a bubble; upstream stages hold, so the same decode re-presents next cycle.
//   4. Otherwise: load all inputs; valid_o <= 1.
//  Bubble: every registered output = 0 (EX_ctrl = 0, MEM_ctrl = 00, WB_ctrl = 0), valid_o = 0.
//   - All-zero MEM/WB fields guarantee no memory access and no register write.
//  A load-use stall lasts exactly one cycle.
//   - After the bubble, valid_o = 0, so load_in_ex = 0 and stall_o drops.
//  Back-to-back loads with a dependency: each consumer stalls exactly once.
//  Reset asserted mid-operation: outputs clear immediately; no state survives deassertion.
// TESTING
//  1. Reset: pulse rst_i with random inputs -> all outputs 0, valid_o = 0, stall_o = 0, asynchronously.
//  2. Pass-through: ADD with EX = 5'b000_0_1, MEM = 00, WB = 1, rs = 3, rt = 4, rd = 5, rs_data = 32'h10
//     -> identical fields one edge later, valid_o = 1.
//  3. Load-use: LW writing rt = 8 in EX (MEM = 10); decode presents rs = 8
//     -> stall_o = 1; next edge: bubble, valid_o = 0; following edge: the consumer is latched.
//  4. $zero exemption: LW writing rt = 0 in EX; decode rs = 0 -> stall_o = 0; consumer latched directly.
//  5. Priority: flush_i = 1 in the same cycle as a load-use match -> bubble, stall_o = 0.
//     hold_i = 1 together with flush_i -> outputs unchanged.
//  6. Hold: freeze for 3 cycles with changing inputs -> outputs stable.
//     Release -> the current inputs latch on the next edge.

Source files
------------

// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use stall and bubble insertion
module id_ex_stage_reg #(
  parameter int DATA_W    = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 hold_i,
  input  logic [4:0]           EX_ctrl_i,
  input  logic [1:0]           MEM_ctrl_i,
  input  logic                 WB_ctrl_i,
  input  logic [DATA_W-1:0]    pc_i,
  input  logic [DATA_W-1:0]    rs_data_i,
  input  logic [DATA_W-1:0]    rt_data_i,
  input  logic [DATA_W-1:0]    imm_i,
  input  logic [RF_ADDR_W-1:0] rs_addr_i,
  input  logic [RF_ADDR_W-1:0] rt_addr_i,
  input  logic [RF_ADDR_W-1:0] rd_addr_i,
  output logic [4:0]           EX_ctrl_o,
  output logic [1:0]           MEM_ctrl_o,
  output logic                 WB_ctrl_o,
  output logic [DATA_W-1:0]    pc_o,
  output logic [DATA_W-1:0]    rs_data_o,
  output logic [DATA_W-1:0]    rt_data_o,
  output logic [DATA_W-1:0]    imm_o,
  output logic [RF_ADDR_W-1:0] rs_addr_o,
  output logic [RF_ADDR_W-1:0] rt_addr_o,
  output logic [RF_ADDR_W-1:0] rd_addr_o,
  output logic                 valid_o,
  output logic                 stall_o
);

  logic load_in_ex;
  logic load_use;

  // Both source fields are compared for every opcode; an occasional extra stall is harmless.
  assign load_in_ex = valid_o & MEM_ctrl_o[1] & ~MEM_ctrl_o[0];
  assign load_use   = load_in_ex & (rt_addr_o != '0) &
                      ((rt_addr_o == rs_addr_i) | (rt_addr_o == rt_addr_i));
  assign stall_o    = load_use & ~hold_i & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      EX_ctrl_o  <= '0;
      MEM_ctrl_o <= '0;
      WB_ctrl_o  <= 1'b0;
      pc_o       <= '0;
      rs_data_o  <= '0;
      rt_data_o  <= '0;
      imm_o      <= '0;
      rs_addr_o  <= '0;
      rt_addr_o  <= '0;
      rd_addr_o  <= '0;
      valid_o    <= 1'b0;
    end else if (hold_i) begin
      valid_o    <= valid_o;
    end else if (flush_i || stall_o) begin
      // Bubble: zero MEM/WB controls mean no memory access and no register write.
      EX_ctrl_o  <= '0;
      MEM_ctrl_o <= '0;
      WB_ctrl_o  <= 1'b0;
      pc_o       <= '0;
      rs_data_o  <= '0;
      rt_data_o  <= '0;
      imm_o      <= '0;
      rs_addr_o  <= '0;
      rt_addr_o  <= '0;
      rd_addr_o  <= '0;
      valid_o    <= 1'b0;
    end else begin
      EX_ctrl_o  <= EX_ctrl_i;
      MEM_ctrl_o <= MEM_ctrl_i;
      WB_ctrl_o  <= WB_ctrl_i;
      pc_o       <= pc_i;
      rs_data_o  <= rs_data_i;
      rt_data_o  <= rt_data_i;
      imm_o      <= imm_i;
      rs_addr_o  <= rs_addr_i;
      rt_addr_o  <= rt_addr_i;
      rd_addr_o  <= rd_addr_i;
      valid_o    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - directed self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, hold_i;
  logic [4:0]  EX_ctrl_i;
  logic [1:0]  MEM_ctrl_i;
  logic        WB_ctrl_i;
  logic [31:0] pc_i, rs_data_i, rt_data_i, imm_i;
  logic [4:0]  rs_addr_i, rt_addr_i, rd_addr_i;
  logic [4:0]  EX_ctrl_o;
  logic [1:0]  MEM_ctrl_o;
  logic        WB_ctrl_o;
  logic [31:0] pc_o, rs_data_o, rt_data_o, imm_o;
  logic [4:0]  rs_addr_o, rt_addr_o, rd_addr_o;
  logic        valid_o, stall_o;

  int total = 0;
  int bad   = 0;

  // Packed view of every registered output, in port order, valid_o last.
  wire  [151:0] obs = {EX_ctrl_o, MEM_ctrl_o, WB_ctrl_o, pc_o, rs_data_o, rt_data_o,
                       imm_o, rs_addr_o, rt_addr_o, rd_addr_o, valid_o};
  logic [151:0] exp_v;
  logic [151:0] bubble = '0;

  always #5 clk_i = ~clk_i;

  id_ex_stage_reg #(.DATA_W(32), .RF_ADDR_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .hold_i(hold_i),
    .EX_ctrl_i(EX_ctrl_i), .MEM_ctrl_i(MEM_ctrl_i), .WB_ctrl_i(WB_ctrl_i),
    .pc_i(pc_i), .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i), .rd_addr_i(rd_addr_i),
    .EX_ctrl_o(EX_ctrl_o), .MEM_ctrl_o(MEM_ctrl_o), .WB_ctrl_o(WB_ctrl_o),
    .pc_o(pc_o), .rs_data_o(rs_data_o), .rt_data_o(rt_data_o), .imm_o(imm_o),
    .rs_addr_o(rs_addr_o), .rt_addr_o(rt_addr_o), .rd_addr_o(rd_addr_o),
    .valid_o(valid_o), .stall_o(stall_o)
  );

  // Drives one decode instruction and records what a plain latch of it must look like.
  task automatic put(input logic [4:0] ex, input logic [1:0] mem, input logic wb,
                     input logic [31:0] pc, input logic [31:0] rsd, input logic [31:0] rtd,
                     input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                     input logic [4:0] rd);
    EX_ctrl_i = ex; MEM_ctrl_i = mem; WB_ctrl_i = wb; pc_i = pc;
    rs_data_i = rsd; rt_data_i = rtd; imm_i = imm;
    rs_addr_i = rs; rt_addr_i = rt; rd_addr_i = rd;
    exp_v = {ex, mem, wb, pc, rsd, rtd, imm, rs, rt, rd, 1'b1};
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; flush_i = 1'b0; hold_i = 1'b0;
    put(5'($urandom), 2'b10, 1'b1, $urandom, $urandom, $urandom, $urandom,
        5'd8, 5'd8, 5'($urandom));
    #2;
    total++;
    if (obs !== bubble) begin bad++; $display("FAIL reset_outputs got=%h want=%h", obs, bubble); end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall_o); end
    tick();
    total++;
    if (obs !== bubble) begin bad++; $display("FAIL reset_held got=%h want=%h", obs, bubble); end
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_pass_through();
    @(negedge clk_i);
    put(5'b000_0_1, 2'b00, 1'b1, 32'h0000_0104, 32'h10, 32'h20, 32'h0, 5'd3, 5'd4, 5'd5);
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL pass_stall got=%b want=0", stall_o); end
    tick();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL pass_latch got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_load_use();
    logic [151:0] cons;
    @(negedge clk_i);
    put(5'b000_1_0, 2'b10, 1'b1, 32'h200, 32'h1000, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0);
    tick();
    @(negedge clk_i);
    put(5'b000_0_1, 2'b00, 1'b1, 32'h204, 32'hAA, 32'hBB, 32'h0, 5'd8, 5'd9, 5'd10);
    cons = exp_v;
    #1;
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_stall got=%b want=1", stall_o); end
    tick();
    total++;
    if (obs !== bubble) begin bad++; $display("FAIL lu_bubble got=%h want=%h", obs, bubble); end
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_stall_drop got=%b want=0", stall_o); end
    tick();
    total++;
    if (obs !== cons) begin bad++; $display("FAIL lu_consumer got=%h want=%h", obs, cons); end
  endtask

  task automatic test_zero_exempt();
    @(negedge clk_i);
    put(5'b000_1_0, 2'b10, 1'b1, 32'h300, 32'h0, 32'h0, 32'h8, 5'd2, 5'd0, 5'd0);
    tick();
    @(negedge clk_i);
    put(5'b000_0_1, 2'b00, 1'b1, 32'h304, 32'h0, 32'h5, 32'h0, 5'd0, 5'd0, 5'd6);
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL zero_stall got=%b want=0", stall_o); end
    tick();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL zero_latch got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_priority();
    logic [151:0] keep;
    @(negedge clk_i);
    put(5'b000_1_0, 2'b10, 1'b1, 32'h400, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
    tick();
    @(negedge clk_i);
    put(5'b000_0_1, 2'b00, 1'b1, 32'h404, 32'h1, 32'h2, 32'h0, 5'd8, 5'd3, 5'd4);
    flush_i = 1'b1;
    #1;
    total++;
    if (stall_o !== 1'b0) begin bad++; $display("FAIL prio_flush_stall got=%b want=0", stall_o); end
    tick();
    total++;
    if (obs !== bubble) begin bad++; $display("FAIL prio_flush_bubble got=%h want=%h", obs, bubble); end
    @(negedge clk_i);
    flush_i = 1'b0;
    put(5'b010_0_1, 2'b01, 1'b0, 32'h408, 32'h11, 32'h22, 32'h33, 5'd7, 5'd9, 5'd11);
    keep = exp_v;
    tick();
    @(negedge clk_i);
    hold_i = 1'b1; flush_i = 1'b1;
    put(5'b111_1_1, 2'b11, 1'b1, 32'hFFFF, 32'h1, 32'h1, 32'h1, 5'd1, 5'd1, 5'd1);
    tick();
    total++;
    if (obs !== keep) begin bad++; $display("FAIL prio_hold_flush got=%h want=%h", obs, keep); end
    @(negedge clk_i);
    hold_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_hold();
    logic [151:0] keep;
    @(negedge clk_i);
    put(5'b000_1_0, 2'b10, 1'b1, 32'h500, 32'hDEAD, 32'hBEEF, 32'h10, 5'd4, 5'd12, 5'd0);
    keep = exp_v;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      hold_i = 1'b1;
      put(5'(i + 1), 2'(i), 1'(i), 32'h600 + 32'(i), 32'(i * 3), 32'(i * 7), 32'(i),
          5'd12, 5'(i + 13), 5'(i + 20));
      #1;
      total++;
      if (stall_o !== 1'b0) begin bad++; $display("FAIL hold_stall_%0d got=%b want=0", i, stall_o); end
      tick();
      total++;
      if (obs !== keep) begin bad++; $display("FAIL hold_frozen_%0d got=%h want=%h", i, obs, keep); end
    end
    @(negedge clk_i);
    hold_i = 1'b0;
    put(5'b001_0_1, 2'b00, 1'b1, 32'h700, 32'h77, 32'h88, 32'h99, 5'd14, 5'd15, 5'd16);
    tick();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL hold_release got=%h want=%h", obs, exp_v); end
  endtask

  task automatic test_back_to_back();
    logic [151:0] nxt;
    @(negedge clk_i);
    put(5'b000_1_0, 2'b10, 1'b1, 32'h800, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
    tick();
    @(negedge clk_i);
    put(5'b000_1_0, 2'b10, 1'b1, 32'h804, 32'h0, 32'h0, 32'h4, 5'd8, 5'd9, 5'd0);
    nxt = exp_v;
    #1;
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("FAIL b2b_stall1 got=%b want=1", stall_o); end
    tick();
    total++;
    if (stall_o !== 1'b0 || obs !== bubble) begin
      bad++; $display("FAIL b2b_bubble1 stall=%b got=%h want=%h", stall_o, obs, bubble);
    end
    tick();
    total++;
    if (obs !== nxt) begin bad++; $display("FAIL b2b_load2 got=%h want=%h", obs, nxt); end
    @(negedge clk_i);
    put(5'b000_0_1, 2'b00, 1'b1, 32'h808, 32'h5, 32'h6, 32'h0, 5'd9, 5'd2, 5'd3);
    nxt = exp_v;
    #1;
    total++;
    if (stall_o !== 1'b1) begin bad++; $display("FAIL b2b_stall2 got=%b want=1", stall_o); end
    tick();
    total++;
    if (stall_o !== 1'b0 || obs !== bubble) begin
      bad++; $display("FAIL b2b_bubble2 stall=%b got=%h want=%h", stall_o, obs, bubble);
    end
    tick();
    total++;
    if (obs !== nxt) begin bad++; $display("FAIL b2b_consumer got=%h want=%h", obs, nxt); end
  endtask

  task automatic test_mid_reset();
    @(negedge clk_i);
    put(5'b000_1_0, 2'b10, 1'b1, 32'h900, 32'h0, 32'h0, 32'h0, 5'd1, 5'd8, 5'd0);
    tick();
    @(negedge clk_i);
    put(5'b000_0_1, 2'b00, 1'b1, 32'h904, 32'h1, 32'h2, 32'h0, 5'd8, 5'd3, 5'd4);
    #1;
    rst_i = 1'b1;
    #1;
    total++;
    if (obs !== bubble || stall_o !== 1'b0) begin
      bad++; $display("FAIL midreset_clear stall=%b got=%h want=%h", stall_o, obs, bubble);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    total++;
    if (obs !== exp_v) begin bad++; $display("FAIL midreset_after got=%h want=%h", obs, exp_v); end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_load_use();
    test_zero_exempt();
    test_priority();
    test_hold();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
